// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM responder stand-in.
package sdram_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_DONE    = 2'd2,
        S_REFRESH = 2'd3
    } state_t;

    localparam int AVM_AW = 25;
    localparam int AVM_DW = 32;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/sdram_mem_array.sv
// Single-port synchronous word array with a one-cycle registered, read-enabled output.
module sdram_mem_array #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];
    logic [DW-1:0] rdata_r;

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register holds its value between reads so the output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sdram_responder.sv
// Avalon-MM responder standing in for the SDRAM controller: on-chip array,
// configurable wait-states, periodic refresh stalls and protocol-error flagging.
import sdram_pkg::*;

module sdram_responder #(
    parameter int MEM_AW         = 10,
    parameter int RD_WAIT        = 2,
    parameter int WR_WAIT        = 1,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic [AVM_AW-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [AVM_DW-1:0] avs_writedata,
    output logic [AVM_DW-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic              refresh_busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              proto_err
);

    localparam int RP_W = $clog2(REFRESH_PERIOD);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REFRESH_PERIOD - 1);

    state_t              state_r, next_state_s;
    logic [3:0]          cnt_r, cnt_next_s;
    logic [MEM_AW-1:0]   addr_r;
    logic [AVM_DW-1:0]   wdata_r;
    logic                op_wr_r;
    logic                accept_s;
    logic                err_set_s;
    logic                refresh_take_s;
    logic [3:0]          req_wait_s;
    logic                req_is_wr_s;
    logic [RP_W-1:0]     refresh_cnt_r;
    logic                refresh_pending_r;
    logic                waitrequest_r;
    logic                refresh_busy_r;
    logic [CNT_W-1:0]    rd_count_r, wr_count_r;
    logic                proto_err_r;
    logic                mem_we_s, mem_re_s;
    logic [MEM_AW-1:0]   mem_addr_s;
    logic [AVM_DW-1:0]   mem_rdata_s;
    logic                unused_addr_s;

    // High address bits alias onto the array and are intentionally ignored.
    assign unused_addr_s = ^avs_address[AVM_AW-1:MEM_AW];

    // A simultaneous read and write is serviced as a read.
    assign req_is_wr_s = avs_write && !avs_read;
    assign req_wait_s  = req_is_wr_s ? 4'(WR_WAIT) : 4'(RD_WAIT);

    // Next-state, countdown and error detection.
    always_comb begin
        next_state_s   = state_r;
        cnt_next_s     = cnt_r;
        accept_s       = 1'b0;
        err_set_s      = 1'b0;
        refresh_take_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (refresh_pending_r) begin
                    next_state_s   = S_REFRESH;
                    cnt_next_s     = 4'(REFRESH_CYCLES - 1);
                    refresh_take_s = 1'b1;
                end else if (avs_read || avs_write) begin
                    accept_s  = 1'b1;
                    err_set_s = avs_read && avs_write;
                    if (req_wait_s == 4'd0) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_ACCESS;
                        cnt_next_s   = req_wait_s - 4'd1;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (op_wr_r ? !avs_write : !avs_read) begin
                    next_state_s = S_IDLE;
                    err_set_s    = 1'b1;
                end else begin
                    err_set_s = (avs_address[MEM_AW-1:0] != addr_r);
                    if (cnt_r == 4'd0) begin
                        next_state_s = S_DONE;
                    end else begin
                        cnt_next_s = cnt_r - 4'd1;
                    end
                end
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            S_REFRESH: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = S_IDLE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // The array reads one cycle ahead so data lands on the S_DONE entry edge.
    always_comb begin
        mem_addr_s = (state_r == S_IDLE) ? avs_address[MEM_AW-1:0] : addr_r;
        mem_we_s   = (state_r == S_DONE) && op_wr_r;
        if (next_state_s == S_DONE) begin
            mem_re_s = (state_r == S_IDLE) ? !req_is_wr_s : !op_wr_r;
        end else begin
            mem_re_s = 1'b0;
        end
    end

    // FSM state, countdown and registered handshake outputs.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_r        <= S_IDLE;
            cnt_r          <= 4'd0;
            waitrequest_r  <= 1'b1;
            refresh_busy_r <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            cnt_r          <= cnt_next_s;
            waitrequest_r  <= (next_state_s != S_DONE);
            refresh_busy_r <= (next_state_s == S_REFRESH);
        end
    end

    // Transfer latches, captured only at acceptance.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            op_wr_r <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= avs_address[MEM_AW-1:0];
            wdata_r <= avs_writedata;
            op_wr_r <= req_is_wr_s;
        end
    end

    // Free-running refresh timer; wraps while pending merge into one request.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            refresh_cnt_r     <= '0;
            refresh_pending_r <= 1'b0;
        end else begin
            refresh_cnt_r <= (refresh_cnt_r == RP_LAST) ? '0 : refresh_cnt_r + 1'b1;
            if (refresh_cnt_r == RP_LAST) begin
                refresh_pending_r <= 1'b1;
            end else if (refresh_take_s) begin
                refresh_pending_r <= 1'b0;
            end
        end
    end

    // Saturating transfer statistics and the sticky protocol-error flag.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            rd_count_r  <= '0;
            wr_count_r  <= '0;
            proto_err_r <= 1'b0;
        end else begin
            if (state_r == S_DONE && !op_wr_r && rd_count_r != 16'hFFFF) begin
                rd_count_r <= rd_count_r + 16'd1;
            end
            if (state_r == S_DONE && op_wr_r && wr_count_r != 16'hFFFF) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
            if (err_set_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    sdram_mem_array #(
        .AW (MEM_AW),
        .DW (AVM_DW)
    ) u_mem (
        .clk   (avm_clk),
        .rst_n (avm_rst),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (mem_addr_s),
        .wdata (wdata_r),
        .rdata (mem_rdata_s)
    );

    assign avs_readdata    = mem_rdata_s;
    assign avs_waitrequest = waitrequest_r;
    assign refresh_busy    = refresh_busy_r;
    assign rd_count        = rd_count_r;
    assign wr_count        = wr_count_r;
    assign proto_err       = proto_err_r;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: vector table plus hand-written
// sequences for refresh collision, abort, mid-transfer reset and read+write.
module tb_sdram_responder;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b0;
    logic [24:0] avs_address = 25'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        refresh_busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        proto_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rd_exp = 0;
    int wr_exp = 0;

    sdram_responder dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .refresh_busy    (refresh_busy),
        .rd_count        (rd_count),
        .wr_count        (wr_count),
        .proto_err       (proto_err)
    );

    always #5 avm_clk = ~avm_clk;

    // Independent model of the refresh timer: cycles since reset release.
    always @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [24:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; waits until a transfer cannot collide with a refresh.
    task automatic align();
        int guard = 0;
        while (((cyc % 64) < 8 || (cyc % 64) > 56) && guard < 200) begin
            @(posedge avm_clk); #1;
            guard++;
        end
    endtask

    // Called at posedge+1; lat counts cycles from request to waitrequest low.
    task automatic xfer(input logic rd, input logic wr, input logic [24:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rdq, output int busy);
        bit done = 1'b0;
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
        lat = 0; busy = 0; rdq = 32'd0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge avm_clk);
            if (refresh_busy) busy++;
            if (!avs_waitrequest) begin
                done = 1'b1;
                rdq  = avs_readdata;
            end else begin
                lat++;
            end
        end
        if (!done) lat = -1;
        @(posedge avm_clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    initial begin
        int          lat, busy, hi;
        logic [31:0] rdq;

        vecs[0] = '{1'b0, 1'b1, 25'h0000005, 32'hDEADBEEF, 2, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 25'h0000005, 32'h0,        3, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 25'h0000400, 32'h00000001, 2, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 25'h0000000, 32'h0,        3, 32'h00000001};
        vecs[4] = '{1'b0, 1'b1, 25'h00003FF, 32'hA5A5A5A5, 2, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 25'h00003FF, 32'h0,        3, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b1, 25'h0000007, 32'h12345678, 2, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 25'h0000007, 32'h0,        3, 32'h12345678};
        vecs[8] = '{1'b0, 1'b1, 25'h0000009, 32'hCAFEF00D, 2, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 25'h1000009, 32'h0,        3, 32'hCAFEF00D};

        #12;
        check("reset_waitreq", 32'(avs_waitrequest), 32'd1);
        check("reset_readdata", avs_readdata, 32'd0);
        check("reset_busy", 32'(refresh_busy), 32'd0);
        check("reset_rdcnt", 32'(rd_count), 32'd0);
        check("reset_wrcnt", 32'(wr_count), 32'd0);
        check("reset_err", 32'(proto_err), 32'd0);
        #10 avm_rst = 1'b1;
        @(posedge avm_clk); #1;

        for (int i = 0; i < 10; i++) begin
            align();
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdq, busy);
            if (vecs[i].rd) rd_exp++; else wr_exp++;
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), rdq, vecs[i].rdata);
            check($sformatf("vec%0d_rdcnt", i), 32'(rd_count), 32'(rd_exp));
            check($sformatf("vec%0d_wrcnt", i), 32'(wr_count), 32'(wr_exp));
            check($sformatf("vec%0d_err", i), 32'(proto_err), 32'd0);
        end

        // Read issued in the exact cycle the refresh request first appears.
        begin
            int guard = 0;
            while ((cyc % 64) != 0 && guard < 200) begin
                @(posedge avm_clk); #1;
                guard++;
            end
        end
        xfer(1'b1, 1'b0, 25'h5, 32'h0, lat, rdq, busy);
        rd_exp++;
        check("refresh_lat", 32'(lat), 32'd8);
        check("refresh_busy_len", 32'(busy), 32'd4);
        check("refresh_rdata", rdq, 32'hDEADBEEF);
        check("refresh_rdcnt", 32'(rd_count), 32'(rd_exp));

        // Read dropped one cycle into the access phase.
        align();
        avs_read = 1'b1; avs_address = 25'h5;
        @(posedge avm_clk); #1;
        avs_read = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge avm_clk);
            if (avs_waitrequest) hi++;
        end
        check("abort_waitreq_high", 32'(hi), 32'd6);
        check("abort_err", 32'(proto_err), 32'd1);
        check("abort_rdcnt", 32'(rd_count), 32'(rd_exp));

        // Reset while a write to 0x9 is in its access phase.
        @(posedge avm_clk); #1;
        align();
        avs_write = 1'b1; avs_address = 25'h9; avs_writedata = 32'h22222222;
        @(posedge avm_clk); #1;
        avm_rst = 1'b0;
        #1;
        check("midrst_waitreq", 32'(avs_waitrequest), 32'd1);
        check("midrst_rdcnt", 32'(rd_count), 32'd0);
        check("midrst_wrcnt", 32'(wr_count), 32'd0);
        check("midrst_err", 32'(proto_err), 32'd0);
        check("midrst_readdata", avs_readdata, 32'd0);
        avs_write = 1'b0;
        rd_exp = 0; wr_exp = 0;
        @(negedge avm_clk);
        avm_rst = 1'b1;
        @(posedge avm_clk); #1;
        align();
        xfer(1'b1, 1'b0, 25'h9, 32'h0, lat, rdq, busy);
        rd_exp++;
        check("midrst_old_value", rdq, 32'hCAFEF00D);

        // Read and write together on a word holding known data.
        align();
        xfer(1'b1, 1'b1, 25'h7, 32'hFFFFFFFF, lat, rdq, busy);
        rd_exp++;
        check("rw_lat", 32'(lat), 32'd3);
        check("rw_rdata", rdq, 32'h12345678);
        check("rw_err", 32'(proto_err), 32'd1);
        check("rw_wrcnt", 32'(wr_count), 32'(wr_exp));
        check("rw_rdcnt", 32'(rd_count), 32'(rd_exp));
        align();
        xfer(1'b1, 1'b0, 25'h7, 32'h0, lat, rdq, busy);
        check("rw_mem_unchanged", rdq, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
